// File: rtl/ft_pkg.sv
// Shared types and debug-address defaults for the FT debug reader and restore writer.
package ft_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ISSUE,
        S_WAIT_DATA,
        S_DONE
    } ft_state_e;

    typedef logic [4:0] snap_idx_t;

    localparam logic [14:0] DBG_GPR_BASE = 15'h0400;
    localparam logic [14:0] DBG_NPC_ADDR = 15'h2000;

    // Index 0 selects the next-PC phase rather than x0.
    function automatic logic [14:0] dbg_addr(input snap_idx_t idx,
                                             input logic [14:0] gpr_base,
                                             input logic [14:0] npc_addr);
        return (idx == 5'd0) ? npc_addr : gpr_base + {8'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/ft_snap_buf.sv
// Snapshot register file: 32-bit entries for x1..x31, one write port, combinational read, x0 reads 0.
module ft_snap_buf
    import ft_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  snap_idx_t   waddr_i,
    input  logic [31:0] wdata_i,
    input  snap_idx_t   raddr_i,
    output logic [31:0] rdata_o
);

    // Entry 0 is never written, so it reduces to a constant.
    logic [31:0][31:0] mem_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (raddr_i == 5'd0) ? 32'd0 : mem_q[raddr_i];

endmodule

// File: rtl/ft_dbg_reader.sv
// Debug-bus snapshot reader: halts the core, reads x1..x31 then the next PC into a buffer.
// Optional per-transaction watchdog enabled by defining FT_DBG_TIMEOUT_EN.
module ft_dbg_reader #(
    parameter logic [14:0] DBG_GPR_BASE  = ft_pkg::DBG_GPR_BASE,
    parameter logic [14:0] DBG_NPC_ADDR  = ft_pkg::DBG_NPC_ADDR,
    parameter bit          RESUME_AT_END = 1'b1
`ifdef FT_DBG_TIMEOUT_EN
    , parameter int        TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        halt_o,
    output logic        resume_o,
    input  logic        halted_i,
    output logic        debug_req_o,
    input  logic        debug_gnt_i,
    input  logic        debug_rvalid_i,
    output logic [14:0] debug_addr_o,
    output logic        debug_we_o,
    input  logic [31:0] debug_rdata_i,
    input  logic [4:0]  rd_idx_i,
    output logic [31:0] rd_data_o,
    output logic [31:0] spc_o
`ifdef FT_DBG_TIMEOUT_EN
    , output logic      timeout_o
`endif
);
    import ft_pkg::*;

    ft_state_e   state_q, state_d;
    snap_idx_t   idx_q, idx_d;
    logic [31:0] spc_q, spc_d;
    logic        wr_en;
    logic        active;

    assign active     = (state_q == S_HALT) || (state_q == S_ISSUE) || (state_q == S_WAIT_DATA);
    assign busy_o     = active;
    assign debug_we_o = 1'b0;
    assign spc_o      = spc_q;

`ifdef FT_DBG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          tmo_q, tmo_d, tmo_hit;

    assign tmo_hit   = active && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_o = tmo_q;

    // Counts cycles spent in the current state; any transition restarts it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= (!active || state_d != state_q) ? '0 : cnt_q + 1'b1;
            tmo_q <= tmo_d;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd1;
            spc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            spc_q   <= spc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        spc_d        = spc_q;
        wr_en        = 1'b0;
        halt_o       = 1'b0;
        debug_req_o  = 1'b0;
        debug_addr_o = '0;
        done_o       = 1'b0;
        resume_o     = 1'b0;
`ifdef FT_DBG_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_HALT;
                    idx_d   = 5'd1;
`ifdef FT_DBG_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            S_HALT: begin
                halt_o = 1'b1;
                if (halted_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                halt_o       = 1'b1;
                debug_req_o  = 1'b1;
                debug_addr_o = dbg_addr(idx_q, DBG_GPR_BASE, DBG_NPC_ADDR);
                if (debug_gnt_i) state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                halt_o = 1'b1;
                if (debug_rvalid_i) begin
                    if (idx_q == 5'd0) begin
                        spc_d   = debug_rdata_i;
                        state_d = S_DONE;
                    end else begin
                        wr_en   = 1'b1;
                        idx_d   = (idx_q == 5'd31) ? 5'd0 : idx_q + 5'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                done_o   = 1'b1;
                resume_o = RESUME_AT_END;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef FT_DBG_TIMEOUT_EN
        // Watchdog overrides any same-cycle progress so partial contents stay as they were.
        if (tmo_hit) begin
            state_d = S_DONE;
            idx_d   = idx_q;
            spc_d   = spc_q;
            wr_en   = 1'b0;
            tmo_d   = 1'b1;
        end
`endif
    end

    ft_snap_buf u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_en),
        .waddr_i (idx_q),
        .wdata_i (debug_rdata_i),
        .raddr_i (rd_idx_i),
        .rdata_o (rd_data_o)
    );

endmodule

// File: tb/tb_ft_dbg_reader.sv
// Directed bench for ft_dbg_reader with a simple debug-port responder and protocol monitor.
module tb_ft_dbg_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, halt, resume;
    logic        halted = 1'b1;
    logic        req, gnt, rvalid, we;
    logic [14:0] addr;
    logic [31:0] rdata;
    logic [4:0]  rd_idx = 5'd0;
    logic [31:0] rd_data, spc;
`ifdef FT_DBG_TIMEOUT_EN
    logic        timeout;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ft_dbg_reader #(
        .RESUME_AT_END (1'b1)
`ifdef FT_DBG_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .busy_o         (busy),
        .done_o         (done),
        .halt_o         (halt),
        .resume_o       (resume),
        .halted_i       (halted),
        .debug_req_o    (req),
        .debug_gnt_i    (gnt),
        .debug_rvalid_i (rvalid),
        .debug_addr_o   (addr),
        .debug_we_o     (we),
        .debug_rdata_i  (rdata),
        .rd_idx_i       (rd_idx),
        .rd_data_o      (rd_data),
        .spc_o          (spc)
`ifdef FT_DBG_TIMEOUT_EN
        , .timeout_o    (timeout)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responder: drives 2 time units after each rising edge.
    int          gnt_delay = 0;
    logic [31:0] data_base = 32'hA000_0000;
    logic        inj_rv = 1'b0;
    logic        withhold = 1'b0;

    function automatic logic [31:0] model(input logic [14:0] a);
        if (a == 15'h2000) return 32'h0000_0124;
        return data_base + 32'((a - 15'h0400) >> 2);
    endfunction

    initial begin
        int          stall;
        logic        pend;
        logic [14:0] pend_addr;
        stall = 0; pend = 1'b0; pend_addr = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(posedge clk); #2;
            gnt    = 1'b0;
            rvalid = inj_rv;
            rdata  = 32'hDEAD_BEEF;
            if (rst) begin
                pend = 1'b0; stall = 0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (!(withhold && pend_addr == 15'h041C)) begin
                        rvalid = 1'b1;
                        rdata  = model(pend_addr);
                    end
                end
                if (req) begin
                    if (stall < gnt_delay) stall++;
                    else begin
                        gnt = 1'b1; stall = 0; pend = 1'b1; pend_addr = addr;
                    end
                end
            end
        end
    end

    // Monitor: samples at the falling edge, mid-cycle.
    logic [14:0] addr_log[$];
    int done_cnt, resume_cnt, stall_err, we_err, halt_err, early_req;

    task automatic clr_mon();
        addr_log.delete();
        done_cnt = 0; resume_cnt = 0; stall_err = 0; we_err = 0; halt_err = 0; early_req = 0;
    endtask

    initial begin
        logic        prev_stall;
        logic [14:0] prev_addr;
        prev_stall = 1'b0; prev_addr = '0;
        clr_mon();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall && (!req || addr != prev_addr)) stall_err++;
                if (we !== 1'b0) we_err++;
                if (halt !== busy) halt_err++;
                if (req && !halted) early_req++;
                if (done) done_cnt++;
                if (resume) resume_cnt++;
                if (req && gnt) addr_log.push_back(addr);
                prev_stall = req && !gnt;
                prev_addr  = addr;
            end else prev_stall = 1'b0;
        end
    end

    task automatic begin_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // Latency counted in rising edges since the one that sampled start.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (lat > 1000) begin
                chk("done_timeout", 32'(lat), 32'd0);
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic rd(input int i, output logic [31:0] d);
        rd_idx = 5'(i);
        #1 d = rd_data;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] base);
        logic [31:0] d;
        int errs = 0;
        for (int i = 1; i < 32; i++) begin
            rd(i, d);
            if (d !== base + 32'(i)) errs++;
        end
        chk(tag, 32'(errs), 32'd0);
    endtask

    initial begin
        int          lat;
        int          bad;
        logic [31:0] d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halt_req", {30'd0, halt, req}, 0);
        chk("rst_done_resume", {30'd0, done, resume}, 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_spc", spc, 0);
        rd(5, d); chk("rst_buf5", d, 0);
`ifdef FT_DBG_TIMEOUT_EN
        chk("rst_timeout", 32'(timeout), 0);
`endif
        @(posedge clk); #2 rst = 1'b0;

        // Ideal responder, core already halted
        clr_mon();
        begin_start();
        wait_done(1, lat);
        chk("t1_latency", 32'(lat), 32'd66);
        chk("t1_resume_at_done", 32'(resume), 1);
        @(posedge clk); #3;
        rd(5, d); chk("t1_buf5", d, 32'hA000_0005);
        rd(0, d); chk("t1_buf0", d, 0);
        chk("t1_spc", spc, 32'h0000_0124);
        chk_all("t1_all", 32'hA000_0000);
        chk("t1_resume_cnt", 32'(resume_cnt), 1);
        chk("t1_done_cnt", 32'(done_cnt), 1);
        chk("t1_busy_after", 32'(busy), 0);

        // Delayed grant: address sequence and stall stability
        clr_mon();
        gnt_delay = 3;
        begin_start();
        wait_done(1, lat);
        chk("t2_latency", 32'(lat), 32'd162);
        chk("t2_hs_cnt", 32'(addr_log.size()), 32);
        bad = 0;
        for (int i = 0; i < addr_log.size(); i++)
            if (addr_log[i] != ((i == 31) ? 15'h2000 : 15'h0404 + 15'(i * 4))) bad++;
        chk("t2_addr_seq", 32'(bad), 0);
        chk("t2_stall_stable", 32'(stall_err), 0);
        chk("t2_we_zero", 32'(we_err), 0);
        gnt_delay = 0;

        // Halt wait: halted_i rises 10 cycles after start
        clr_mon();
        halted = 1'b0;
        begin_start();
        @(negedge clk);
        chk("t3_halt_cycle1", {31'd0, halt}, 1);
        repeat (9) @(posedge clk);
        #2 halted = 1'b1;
        wait_done(10, lat);
        chk("t3_latency", 32'(lat), 32'd75);
        chk("t3_no_early_req", 32'(early_req), 0);
        chk("t3_halt_level", 32'(halt_err), 0);

        // Spurious rvalid in IDLE and ISSUE, start while busy
        clr_mon();
        @(posedge clk); #3 inj_rv = 1'b1;
        @(posedge clk); #3 inj_rv = 1'b0;
        rd(1, d); chk("t4_idle_rvalid", d, 32'hA000_0001);
        data_base = 32'hB000_0000;
        gnt_delay = 2;
        begin_start();
        bad = 0;
        do begin @(negedge clk); bad++; end while (!(req && addr == 15'h0414) && bad < 500);
        inj_rv = 1'b1;
        @(posedge clk); #3 inj_rv = 1'b0;
        start = 1'b1;
        @(posedge clk); #3 start = 1'b0;
        wait_done(0, lat);
        repeat (3) @(posedge clk);
        #3;
        chk_all("t4_all", 32'hB000_0000);
        chk("t4_done_once", 32'(done_cnt), 1);
        chk("t4_busy_after", 32'(busy), 0);
        gnt_delay = 0;

        // Reset during idx 12
        clr_mon();
        data_base = 32'hC000_0000;
        begin_start();
        bad = 0;
        do begin @(negedge clk); bad++; end while (!(req && addr == 15'h0430) && bad < 500);
        rst = 1'b1;
        #1;
        chk("t5_rst_halt_req", {30'd0, halt, req}, 0);
        chk("t5_rst_busy", 32'(busy), 0);
        rd(1, d); chk("t5_rst_buf1", d, 0);
        chk("t5_rst_spc", spc, 0);
        @(posedge clk); #1;
        chk("t5_no_resume", 32'(resume_cnt), 0);
        @(posedge clk); #2 rst = 1'b0;
        clr_mon();
        begin_start();
        wait_done(1, lat);
        chk("t5_latency", 32'(lat), 32'd66);
        @(posedge clk); #3;
        chk_all("t5_all", 32'hC000_0000);
        chk("t5_spc", spc, 32'h0000_0124);

`ifdef FT_DBG_TIMEOUT_EN
        // Watchdog: rvalid withheld on x7
        clr_mon();
        data_base = 32'hD000_0000;
        withhold = 1'b1;
        begin_start();
        wait_done(1, lat);
        chk("t6_latency", 32'(lat), 32'd31);
        chk("t6_resume", 32'(resume), 1);
        @(posedge clk); #3;
        withhold = 1'b0;
        chk("t6_timeout", 32'(timeout), 1);
        rd(7, d); chk("t6_buf7_kept", d, 32'hC000_0007);
        rd(6, d); chk("t6_buf6_new", d, 32'hD000_0006);
        chk("t6_spc_kept", spc, 32'h0000_0124);
        chk("t6_done_once", 32'(done_cnt), 1);
        begin_start();
        @(negedge clk);
        chk("t6_timeout_clr", 32'(timeout), 0);
        wait_done(1, lat);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ft_dbg_reader.md
Name: ft_dbg_reader

Overview:
- Debug-bus read initiator for the lockstep FT subsystem; it is the reading counterpart of the fault-tolerance register-restore writer.
- Halts a core and reads GPRs x1..x31 plus the next PC through the core's debug port (req/gnt/rvalid). It stores them in a snapshot buffer.
- The FT controller or restore path reads the snapshot afterwards through an indexed read port.

Parameters:
- DBG_GPR_BASE, 15'h0400, debug address of x0; GPR n is at DBG_GPR_BASE + (n<<2).
- DBG_NPC_ADDR, 15'h2000, debug address of the next PC.
- RESUME_AT_END, 1, when 1, pulse resume_o after the final read.
- TIMEOUT_CYCLES, 64, per-transaction watchdog limit; used only with FT_DBG_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  capture request; sampled in IDLE only
- busy_o  out  1  high from the cycle after an accepted start until DONE
- done_o  out  1  one-cycle pulse when the snapshot is complete
- halt_o  out  1  core halt request, level
- resume_o  out  1  core resume, one-cycle pulse
- halted_i  in  1  core debug_halted
- debug_req_o  out  1  debug request
- debug_gnt_i  in  1  debug grant
- debug_rvalid_i  in  1  debug read data valid
- debug_addr_o  out  15  debug address
- debug_we_o  out  1  tied 0; read-only initiator
- debug_rdata_i  in  32  debug read data
- rd_idx_i  in  5  snapshot read index
- rd_data_o  out  32  snapshot[rd_idx_i]; combinational; index 0 returns 0
- spc_o  out  32  captured next PC
- timeout_o  out  1  sticky transaction-timeout flag; exists only with FT_DBG_TIMEOUT_EN

Behaviour:
- Reset values:
  - state = IDLE; all outputs 0; idx = 1.
  - Buffer and spc_o are cleared to 0.
- States:
  - IDLE: start_i -> HALT; idx <= 1.
  - HALT: halt_o = 1 from this state through ISSUE/WAIT_DATA until DONE. When halted_i = 1 -> ISSUE. A core that is already halted gives a 1-cycle HALT.
  - ISSUE: debug_req_o = 1; addr = GPR(idx), or DBG_NPC_ADDR when idx == 0 (the PC phase). Req and addr are held stable until gnt; on gnt -> WAIT_DATA.
  - WAIT_DATA: req = 0. On rvalid, store rdata to buf[idx] (or spc_o in the PC phase).
    - idx == 31: idx <= 0 (PC phase), -> ISSUE.
    - PC phase: -> DONE.
    - Otherwise: idx++, -> ISSUE.
  - DONE: done_o = 1 for 1 cycle; halt_o drops. resume_o = RESUME_AT_END for this cycle. -> IDLE.
- Protocol rules:
  - Exactly one outstanding transaction.
  - rvalid is sampled only in WAIT_DATA, from the cycle after gnt. rvalid seen in any other state is ignored.
  - With gnt in the same cycle as req and rvalid in the next cycle, each read takes 2 cycles.
  - Total = 32 reads; start to done = 1 + H + 64 cycles minimum, where H is the number of halt-wait cycles.
- Boundary conditions:
  - start_i while busy is ignored.
  - halted_i dropping mid-capture is ignored; the core owns that error.
  - Buffer contents persist after done until the next start overwrites them entry by entry. rd_data_o may show mixed old and new snapshots while busy.
  - Reset mid-operation aborts immediately: halt_o = 0 and req = 0. No resume pulse is issued.
- Width rule: addresses are computed in 15 bits. Max GPR address is 0x47C, so there is no wrap.

Optional Feature:
- Macro: FT_DBG_TIMEOUT_EN.
- When defined:
  - A counter runs in HALT, ISSUE and WAIT_DATA and resets on every state change.
  - Reaching TIMEOUT_CYCLES sets timeout_o (sticky until reset or next accepted start) and jumps to DONE.
  - DONE behaves as normal (done_o pulse, halt_o released, resume_o per RESUME_AT_END); spc_o and buffer keep partial contents.
- When undefined: no counter and no timeout_o port; the FSM may wait forever.

Decomposition:
- Package ft_pkg holds:
  - the state enum typedef;
  - DBG_GPR_BASE and DBG_NPC_ADDR defaults, shared with the restore writer;
  - the snapshot index typedef (logic [4:0]).
- One natural sub-module, ft_snap_buf: 31x32 register array, single write port, combinational read, entry 0 hard-wired to 0.

Test Plan:
- Ideal responder: start with halted_i already 1, gnt same cycle, rvalid next cycle, rdata = 0xA000_0000 + n for GPR n and PC = 0x0000_0124. Expected: done 66 cycles after start; rd_data(5) = 0xA000_0005; rd_data(0) = 0; spc_o = 0x124; resume_o pulses once.
- Address and handshake: gnt delayed 3 cycles per request. Expected: debug_addr_o sequence 0x404, 0x408 … 0x47C, 0x2000; req and addr stable during each stall; exactly one req-gnt per address; debug_we_o always 0.
- Halt wait: halted_i rises 10 cycles after start. Expected: halt_o high from cycle 1 until DONE; no debug_req_o before halted_i.
- Spurious inputs: rvalid pulsed in IDLE and ISSUE, start_i pulsed mid-capture. Expected: buffer unaffected; capture completes once; single done_o pulse.
- Reset mid-capture: assert rst_i during idx = 12. Expected: same cycle (async), all outputs 0 and buffer cleared; a following start gives a correct full snapshot.
- With FT_DBG_TIMEOUT_EN and TIMEOUT_CYCLES = 16: withhold rvalid on x7. Expected: timeout_o set after 16 cycles; done_o pulses; buf[7] unchanged.
